// File: rtl/wisc_pkg.sv
// Shared WISC CPU definitions: opcodes, reset/bubble constants and the fetch FSM encoding.
package wisc_pkg;

    localparam logic [3:0]  OPC_HLT      = 4'hF;
    localparam logic [15:0] PC_RESET     = 16'h0000;
    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc2} holding register that catches a fetch completing while ID is stalled.
module fetch_skid_buf
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc2_i,
    output logic        valid_o,
    output logic [15:0] instr_o,
    output logic [15:0] pc2_o
);

    logic        r_valid;
    logic [15:0] r_instr;
    logic [15:0] r_pc2;

    // A flush beats a load so a squashed fetch can never survive in the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= BUBBLE_INSTR;
            r_pc2   <= PC_RESET;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_instr <= instr_i;
            r_pc2   <= pc2_i;
        end else if (unload_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign instr_o = r_instr;
    assign pc2_o   = r_pc2;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: PC, imem handshake, IF/ID register, skid buffer and redirect handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_rdy_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] pc_o,
    output logic [15:0] if_id_instr_o,
    output logic [15:0] if_id_pc2_o,
    output logic        if_id_valid_o,
    output logic        halt_fetched_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] miss_cnt_o
`endif
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic [15:0]  r_target;
    logic [15:0]  r_if_id_instr;
    logic [15:0]  r_if_id_pc2;
    logic         r_if_id_valid;

    logic         w_req;
    logic         w_accept;
    logic         w_outstanding;
    logic [15:0]  w_pc_plus2;
    logic         w_data_hlt;
    logic         w_load_imem;
    logic         w_load_skid;
    logic         w_unload_skid;
    logic         w_bubble;
    logic         w_skid_valid;
    logic [15:0]  w_skid_instr;
    logic [15:0]  w_skid_pc2;

    assign w_req         = (r_state != HALTED) && !w_skid_valid && rst_n;
    assign w_accept      = w_req && imem_rdy_i;
    assign w_outstanding = w_req && !imem_rdy_i;
    assign w_pc_plus2    = r_pc + 16'd2;
    assign w_data_hlt    = is_hlt(imem_data_i);

    assign w_load_imem   = !redirect_i && (r_state == FETCH) && w_accept && !stall_i;
    assign w_load_skid   = !redirect_i && (r_state == FETCH) && w_accept && stall_i;
    assign w_unload_skid = !redirect_i && w_skid_valid && !stall_i;
    // Once halted, IF/ID keeps presenting the HLT instead of draining to a bubble.
    assign w_bubble      = redirect_i ||
                           (!stall_i && (r_state != HALTED) && !w_load_imem && !w_unload_skid);

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_load_skid),
        .unload_i (w_unload_skid),
        .clear_i  (redirect_i),
        .instr_i  (imem_data_i),
        .pc2_i    (w_pc_plus2),
        .valid_o  (w_skid_valid),
        .instr_o  (w_skid_instr),
        .pc2_o    (w_skid_pc2)
    );

    // The request address is r_pc throughout DISCARD; the target waits in r_target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= PC_RESET;
            r_target <= PC_RESET;
        end else if (redirect_i) begin
            if (w_outstanding) begin
                r_target <= redirect_pc_i;
                r_state  <= DISCARD;
            end else begin
                r_pc    <= redirect_pc_i;
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_accept) begin
                        if (w_data_hlt) begin
                            r_state <= HALTED;
                        end else begin
                            r_pc <= w_pc_plus2;
                        end
                    end
                end
                DISCARD: begin
                    if (w_accept) begin
                        r_pc    <= r_target;
                        r_state <= FETCH;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_id_instr <= BUBBLE_INSTR;
            r_if_id_pc2   <= PC_RESET;
            r_if_id_valid <= 1'b0;
        end else if (w_bubble) begin
            r_if_id_instr <= BUBBLE_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_load_imem) begin
            r_if_id_instr <= imem_data_i;
            r_if_id_pc2   <= w_pc_plus2;
            r_if_id_valid <= 1'b1;
        end else if (w_unload_skid) begin
            r_if_id_instr <= w_skid_instr;
            r_if_id_pc2   <= w_skid_pc2;
            r_if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= 16'h0000;
            r_miss_cnt  <= 16'h0000;
        end else begin
            if ((w_load_imem || w_unload_skid) && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_outstanding && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign miss_cnt_o  = r_miss_cnt;
`endif

    assign imem_req_o     = w_req;
    assign imem_addr_o    = r_pc;
    assign pc_o           = r_pc;
    assign if_id_instr_o  = r_if_id_instr;
    assign if_id_pc2_o    = r_if_id_pc2;
    assign if_id_valid_o  = r_if_id_valid;
    assign halt_fetched_o = r_if_id_valid && is_hlt(r_if_id_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage; random phase checks program order against an imem image.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallIn;
    logic        redirectIn;
    logic [15:0] redirectPc;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemRdy;
    logic [15:0] imemData;
    logic [15:0] pcOut;
    logic [15:0] ifIdInstr;
    logic [15:0] ifIdPc2;
    logic        ifIdValid;
    logic        haltFetched;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetchCnt;
    logic [15:0] missCnt;
`endif

    int testCount = 0;
    int failCount = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stallIn),
        .redirect_i     (redirectIn),
        .redirect_pc_i  (redirectPc),
        .imem_req_o     (imemReq),
        .imem_addr_o    (imemAddr),
        .imem_rdy_i     (imemRdy),
        .imem_data_i    (imemData),
        .pc_o           (pcOut),
        .if_id_instr_o  (ifIdInstr),
        .if_id_pc2_o    (ifIdPc2),
        .if_id_valid_o  (ifIdValid),
        .halt_fetched_o (haltFetched)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o    (fetchCnt),
        .miss_cnt_o     (missCnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction image for the random phase; bit 12 cleared so no word decodes as HLT.
    function automatic logic [15:0] memWord(input logic [15:0] addr);
        logic [15:0] h;
        h = addr * 16'h03A7 + 16'h1234;
        return h & 16'hEFFF;
    endfunction

    task automatic applyStimulus(input logic stall, input logic redir, input logic [15:0] rpc,
                                 input logic rdy, input logic [15:0] data);
        stallIn    = stall;
        redirectIn = redir;
        redirectPc = rpc;
        imemRdy    = rdy;
        imemData   = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        logic        stallR;
        logic        redirR;
        logic        rdyR;
        logic [15:0] targetR;
        logic [15:0] expPc;
        logic        prevOut;
        logic [15:0] prevAddr;
        int          consumed;

        rst_n      = 1'b0;
        stallIn    = 1'b0;
        redirectIn = 1'b0;
        redirectPc = 16'h0000;
        imemRdy    = 1'b0;
        imemData   = 16'h0000;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("reset_pc", pcOut, 16'h0000);
        checkOutput("reset_instr", ifIdInstr, 16'h0000);
        checkOutput("reset_pc2", ifIdPc2, 16'h0000);
        checkOutput("reset_valid", 16'(ifIdValid), 16'h0);
        checkOutput("reset_halt", 16'(haltFetched), 16'h0);
        checkOutput("reset_req", 16'(imemReq), 16'h0);

        rst_n = 1'b1;
        #1;
        checkOutput("first_req", 16'(imemReq), 16'h1);
        checkOutput("first_addr", imemAddr, 16'h0000);

        // Zero-wait stream: one instruction per cycle.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        checkOutput("hit0_instr", ifIdInstr, 16'h1111);
        checkOutput("hit0_pc2", ifIdPc2, 16'h0002);
        checkOutput("hit0_valid", 16'(ifIdValid), 16'h1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
        checkOutput("hit1_instr", ifIdInstr, 16'h2222);
        checkOutput("hit1_pc2", ifIdPc2, 16'h0004);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333);
        checkOutput("hit2_instr", ifIdInstr, 16'h3333);
        checkOutput("hit2_pc2", ifIdPc2, 16'h0006);
        checkOutput("hit2_pc", pcOut, 16'h0006);

        // Fetch completes during a 3-cycle stall and is parked in the skid buffer.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4444);
        checkOutput("skid_hold_instr", ifIdInstr, 16'h3333);
        checkOutput("skid_req", 16'(imemReq), 16'h0);
        checkOutput("skid_pc", pcOut, 16'h0008);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("skid_hold2_instr", ifIdInstr, 16'h3333);
        checkOutput("skid_hold2_req", 16'(imemReq), 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("skid_out_instr", ifIdInstr, 16'h4444);
        checkOutput("skid_out_pc2", ifIdPc2, 16'h0008);
        checkOutput("skid_out_valid", 16'(ifIdValid), 16'h1);
        checkOutput("skid_resume_req", 16'(imemReq), 16'h1);
        checkOutput("skid_resume_addr", imemAddr, 16'h0008);

        // Redirect during a miss: old address held, its data dropped.
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0000);
        checkOutput("redir_pc", pcOut, 16'h0010);
        checkOutput("redir_valid", 16'(ifIdValid), 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        checkOutput("discard_addr", imemAddr, 16'h0010);
        checkOutput("discard_req", 16'(imemReq), 16'h1);
        checkOutput("discard_valid", 16'(ifIdValid), 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("discard_addr2", imemAddr, 16'h0010);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
        checkOutput("discard_drop_valid", 16'(ifIdValid), 16'h0);
        checkOutput("discard_new_addr", imemAddr, 16'h0040);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666);
        checkOutput("target_instr", ifIdInstr, 16'h6666);
        checkOutput("target_pc2", ifIdPc2, 16'h0042);

        // HLT stops fetching; a redirect restarts it.
        applyStimulus(1'b0, 1'b1, 16'h0008, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000);
        checkOutput("hlt_flag", 16'(haltFetched), 16'h1);
        checkOutput("hlt_pc", pcOut, 16'h0008);
        checkOutput("hlt_req", 16'(imemReq), 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("halted_pc", pcOut, 16'h0008);
        checkOutput("halted_req", 16'(imemReq), 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000);
        checkOutput("unhalt_flag", 16'(haltFetched), 16'h0);
        checkOutput("unhalt_req", 16'(imemReq), 16'h1);
        checkOutput("unhalt_addr", imemAddr, 16'h0020);

        // Stall and redirect together: redirect wins.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        checkOutput("pre_flush_instr", ifIdInstr, 16'h7777);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1, 16'h8888);
        checkOutput("flush_valid", 16'(ifIdValid), 16'h0);
        checkOutput("flush_instr", ifIdInstr, 16'h0000);
        checkOutput("flush_pc", pcOut, 16'h0100);
        checkOutput("flush_req", 16'(imemReq), 16'h1);

        // PC wraps modulo 2^16.
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
        checkOutput("wrap_pc2", ifIdPc2, 16'h0000);
        checkOutput("wrap_pc", pcOut, 16'h0000);

        // Reset while a miss is outstanding.
        applyStimulus(1'b0, 1'b1, 16'h0300, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_miss_req", 16'(imemReq), 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("rst_miss_pc", pcOut, 16'h0000);
        checkOutput("rst_miss_valid", 16'(ifIdValid), 16'h0);
        rst_n = 1'b1;

        // Random phase: every instruction ID consumes must follow program order from the image.
        expPc    = 16'h0000;
        prevOut  = 1'b0;
        prevAddr = 16'h0000;
        consumed = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (prevOut) begin
                checkOutput("hold_req", 16'(imemReq), 16'h1);
                checkOutput("hold_addr", imemAddr, prevAddr);
            end
            stallR  = ($urandom % 4) == 0;
            redirR  = !stallR && (($urandom % 16) == 0);
            targetR = 16'($urandom) & 16'hFFFE;
            rdyR    = ($urandom % 3) != 0;
            if (ifIdValid && !stallR) begin
                checkOutput("rand_instr", ifIdInstr, memWord(expPc));
                checkOutput("rand_pc2", ifIdPc2, expPc + 16'd2);
                expPc = expPc + 16'd2;
                consumed++;
            end
            if (redirR) begin
                expPc = targetR;
            end
            prevOut  = imemReq && !rdyR;
            prevAddr = imemAddr;
            applyStimulus(stallR, redirR, targetR, rdyR, memWord(imemAddr));
        end
        checkOutput("rand_progress", 16'(consumed > 200), 16'h1);

`ifdef FETCH_PERF_CNT_EN
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("perf_reset_fetch", fetchCnt, 16'h0000);
        checkOutput("perf_reset_miss", missCnt, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000);
        checkOutput("perf_fetch_cnt", fetchCnt, 16'd5);
        checkOutput("perf_miss_cnt", missCnt, 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the WISC 16-bit pipelined CPU. It owns the PC, issues requests to the instruction memory/cache over a hold-until-ready handshake, and loads the IF/ID pipeline register. It absorbs ID-stage stalls through a one-entry skid buffer and handles branch redirects, including redirects that arrive while a cache miss is outstanding. It also stops fetching on HLT.

## Interface
- No parameters. Widths are fixed: 16-bit PC and instruction.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall_i  in  1  hazard unit: hold IF/ID and PC
- redirect_i  in  1  branch/jump resolved taken in ID
- redirect_pc_i  in  16  redirect target
- imem_req_o  out  1  instruction request valid
- imem_addr_o  out  16  request address (current PC)
- imem_rdy_i  in  1  imem_data_i valid; completes the request
- imem_data_i  in  16  fetched instruction
- pc_o  out  16  current PC (drives cpu `pc`)
- if_id_instr_o  out  16  IF/ID instruction
- if_id_pc2_o  out  16  IF/ID PC+2
- if_id_valid_o  out  1  IF/ID holds a real instruction
- halt_fetched_o  out  1  HLT (opcode 4'hF) is in IF/ID and valid

## Operation
- States:
  - FETCH: normal fetching.
  - DISCARD: a redirect arrived while a request was outstanding.
  - HALTED: HLT has been fetched.
- Handshake:
  - imem_req_o = (state != HALTED) && !skid_valid && rst_n.
  - Once imem_req_o is raised, imem_addr_o is held stable until imem_rdy_i.
  - imem_rdy_i may arrive in the same cycle as the request (zero-wait hit).
- FETCH, rdy=1, stall=0, redirect=0:
  - IF/ID <= {imem_data_i, pc+2, valid=1}.
  - If opcode == 4'hF: go to HALTED, PC unchanged. Otherwise pc <= pc+2.
- FETCH, rdy=1, stall=1: skid <= {data, pc+2}; pc <= pc+2 (PC unchanged if HLT); IF/ID holds.
- Skid valid, stall=0: IF/ID loads from skid, skid clears, and requests resume next cycle.
- Stall with skid already full: everything holds.
- Redirect (highest priority, in any state):
  - Clears IF/ID valid (instr forced to 16'h0000) and clears the skid.
  - If a request is outstanding (req=1, rdy=0): latch the target, go to DISCARD.
  - Otherwise: pc <= redirect_pc_i, state <= FETCH.
- DISCARD:
  - Keep the old address requested until rdy, then drop the data.
  - pc <= latched target, go to FETCH.
  - A second redirect in DISCARD overwrites the latched target.
- HALTED: no requests, PC frozen. Only a redirect leaves it (wrong-path HLT).
- Stall and redirect in the same cycle: redirect wins.
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000.

## Timing
- Reset values:
  - pc_o = 16'h0000, state = FETCH, skid empty.
  - if_id_instr_o = 16'h0000, if_id_pc2_o = 16'h0000, if_id_valid_o = 0, halt_fetched_o = 0.
  - imem_req_o = 0 while rst_n = 0.
- Reset mid-miss: all state clears. Imem must also be reset, because the outstanding request is abandoned.
- IF/ID updates on the clk edge where rdy=1; the instruction is visible to ID on the next cycle.
- Throughput is 1 instr/cycle with zero-wait imem.
- A redirect takes effect on the next edge. The first target fetch is requested the cycle after the redirect, or the cycle after rdy when in DISCARD.
- After a stall drops, the skid-buffered instruction appears with 1-cycle latency.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds fetch_cnt_o[15:0]: increments each time IF/ID loads a valid instruction.
  - Adds miss_cnt_o[15:0]: increments each cycle with req=1 and rdy=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and their logic are absent.

## Structure
- Shared package wisc_pkg holds:
  - OPC_HLT = 4'hF
  - PC_RESET = 16'h0000
  - BUBBLE_INSTR = 16'h0000
  - fetch state enum {FETCH, DISCARD, HALTED}
- One sub-module, fetch_skid_buf: a one-entry {instr, pc2} buffer with load/unload/clear and a valid output.

## Test plan
- Zero-wait imem returning 0x1111, 0x2222, 0x3333 at PC 0, 2, 4 → IF/ID shows each one cycle later with pc2 = 2, 4, 6; valid=1.
- rdy=1 during stall_i=1 for 3 cycles → instruction held in skid, imem_req_o=0, no loss. Instruction appears 1 cycle after stall drops.
- 3-cycle miss at PC 0x0010, redirect to 0x0040 in wait cycle 1 → addr stays 0x0010 until rdy, data dropped, next request at 0x0040, valid=0 meanwhile.
- Fetch 0xF000 at PC 0x0008 → halt_fetched_o=1, pc_o stays 0x0008, no further requests. Redirect to 0x0020 → fetching resumes at 0x0020.
- Stall and redirect to 0x0100 in the same cycle → IF/ID flushed (valid=0), pc_o=0x0100.
- With FETCH_PERF_CNT_EN: 4 hits plus one 2-wait miss → fetch_cnt_o=5, miss_cnt_o=2. Counter preloaded at 16'hFFFF stays at 16'hFFFF.
